// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   localparam int ARB_NUM_REQ    = 4;
   localparam int ARB_MAX_BURST  = 16;
   localparam int ARB_DATA_WIDTH = 8;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake plus the FIFO write port, bundled as one interface.
// The slave modport is the arbiter's view. The master modport is the view of
// whatever drives the requesters and models the FIFO.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = ARB_NUM_REQ,
   parameter int data_width = ARB_DATA_WIDTH
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*data_width-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          full;
   logic                          w_en;
   logic [data_width-1:0]         data_in;

   modport slave (
      input  req_valid, req_data, req_last, full,
      output req_ready, w_en, data_in
   );

   modport master (
      output req_valid, req_data, req_last, full,
      input  req_ready, w_en, data_in
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: returns the first set request at or after ptr_i, searching
// upward and wrapping modulo NUM_REQ. NUM_REQ need not be a power of two.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ = ARB_NUM_REQ,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   int cand;

   // Walk the requests in priority order starting at the pointer and keep the first hit.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no path can infer a latch.
      found = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!found && req_i[IDX_W'(cand)]) begin
            found = 1'b1;
            idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of the async FIFO write side.
// A grant is held for a whole packet, capped at MAX_BURST beats. A write is
// issued only while full is low.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ    = ARB_NUM_REQ,
   parameter  int data_width = ARB_DATA_WIDTH,
   parameter  int MAX_BURST  = ARB_MAX_BURST,
   localparam int IDX_W      = $clog2(NUM_REQ),
   localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
   input  logic                 w_clk,
   input  logic                 wrst_n,
   fifo_wr_arbiter_if.slave     bus,
   output logic [IDX_W-1:0]     gnt_id,
   output logic                 busy
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       gnt_id_q, gnt_id_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;

   logic                   pick_found;
   logic [IDX_W-1:0]       pick_idx;
   logic                   rel_beat;
   logic [NUM_REQ-1:0]     req_ready;
   logic                   w_en;
   logic [data_width-1:0]  data_in;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req_i (bus.req_valid),
      .ptr_i (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // An accepted beat releases the grant when it closes the packet or hits the burst cap.
   assign rel_beat = w_en & (bus.req_last[gnt_id_q] | (beat_cnt_q == LAST_BEAT));

   // State register: FSM state, grant, round-robin pointer and beat counter.
   always_ff @(posedge w_clk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q    <= ARB_IDLE;
         gnt_id_q   <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples values from before the edge.
         state_q    <= state_d;
         gnt_id_q   <= gnt_id_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Next-state logic: arbitrate when idle, count and release beats while granted.
   always_comb begin
      state_d    = state_q;
      gnt_id_d   = gnt_id_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               gnt_id_d   = pick_idx;
               beat_cnt_d = '0;
               state_d    = ARB_BURST;
            end
         end
         ARB_BURST: begin
            if (w_en) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
            if (rel_beat) begin
               rr_ptr_d = (gnt_id_q == LAST_IDX) ? '0 : gnt_id_q + 1'b1;
               state_d  = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Output logic: steer the granted requester onto the FIFO port, gated by full.
   always_comb begin
      req_ready = '0;
      w_en      = 1'b0;
      data_in   = '0;
      if (state_q == ARB_BURST) begin
         req_ready[gnt_id_q] = ~bus.full;
         w_en                = bus.req_valid[gnt_id_q] & ~bus.full;
         data_in             = bus.req_data[gnt_id_q*data_width +: data_width];
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.w_en      = w_en;
   assign bus.data_in   = data_in;
   assign gnt_id        = gnt_id_q;
   assign busy          = (state_q == ARB_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Each requester holds a list of
// packets. A transaction-level model turns those lists into the expected
// write stream, using round-robin order with burst-capped grants. A timing
// model predicts busy: a grant follows the first idle cycle that has a
// pending request, and every release is followed by one idle cycle.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 16;
   localparam int IW = 2;
   localparam int DEPTH = 256;

   logic          w_clk = 1'b0;
   logic          wrst_n;
   logic [IW-1:0] gnt_id;
   logic          busy;

   fifo_wr_arbiter_if #(.NUM_REQ(NR), .data_width(DW)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(NR), .data_width(DW), .MAX_BURST(MB)) dut (
      .w_clk  (w_clk),
      .wrst_n (wrst_n),
      .bus    (bus),
      .gnt_id (gnt_id),
      .busy   (busy)
   );

   always #5 w_clk = ~w_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Per-requester beat store: bit 8 is the last flag, bits 7:0 are the data.
   logic [8:0] mem [NR][DEPTH];
   int         head [NR];
   int         tail [NR];

   // Expected write stream.
   int         exp_gnt  [$];
   logic [7:0] exp_data [$];
   bit         exp_rel  [$];

   int model_ptr;
   bit expect_busy;
   int last_gnt;
   int writes_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_packet(input int r, input int len);
      for (int b = 0; b < len; b++) begin
         mem[r][tail[r]] = {(b == len - 1), 8'($urandom)};
         tail[r]++;
      end
   endtask

   // Expand all pending packets into the write order the arbiter should produce.
   function automatic void build_expect();
      int   h [NR];
      int   g;
      int   c;
      int   n;
      bit   rel;
      logic [8:0] beat;
      for (int r = 0; r < NR; r++) h[r] = head[r];
      while (1) begin
         g = -1;
         for (int k = 0; k < NR; k++) begin
            c = (model_ptr + k) % NR;
            if (g < 0 && h[c] < tail[c]) g = c;
         end
         if (g < 0) break;
         n   = 0;
         rel = 1'b0;
         while (!rel) begin
            beat = mem[g][h[g]];
            h[g]++;
            n++;
            rel = beat[8] || (n == MB);
            exp_gnt.push_back(g);
            exp_data.push_back(beat[7:0]);
            exp_rel.push_back(rel);
         end
         model_ptr = (g + 1) % NR;
      end
   endfunction

   task automatic drive_inputs(input logic full_v, input logic stall_v, output logic any_pend);
      int  g;
      bit  pend;
      g        = (exp_gnt.size() > 0) ? exp_gnt[0] : 0;
      any_pend = 1'b0;
      for (int r = 0; r < NR; r++) begin
         pend                     = head[r] < tail[r];
         any_pend                 = any_pend | pend;
         bus.req_valid[r]         = pend && !(expect_busy && r == g && stall_v);
         bus.req_data[r*DW +: DW] = pend ? mem[r][head[r]][7:0] : 8'h00;
         bus.req_last[r]          = pend ? mem[r][head[r]][8] : 1'b0;
      end
      bus.full = full_v;
   endtask

   task automatic cycle(input logic full_v, input logic stall_v);
      logic any_pend;
      bit   acc;
      int   g;
      @(negedge w_clk);
      drive_inputs(full_v, stall_v, any_pend);
      #1;
      g   = (exp_gnt.size() > 0) ? exp_gnt[0] : 0;
      acc = expect_busy && (exp_gnt.size() > 0) && !full_v && !stall_v;
      check("busy", 32'(busy), 32'(expect_busy));
      if (expect_busy && exp_gnt.size() > 0) begin
         check("gnt_id", 32'(gnt_id), g);
         check("req_ready", 32'(bus.req_ready), full_v ? 0 : (1 << g));
         check("w_en", 32'(bus.w_en), 32'(acc));
         check("data_in", 32'(bus.data_in), 32'(exp_data[0]));
      end else begin
         check("idle_gnt_id", 32'(gnt_id), last_gnt);
         check("idle_req_ready", 32'(bus.req_ready), 0);
         check("idle_w_en", 32'(bus.w_en), 0);
         check("idle_data_in", 32'(bus.data_in), 0);
      end
      if (expect_busy) expect_busy = !(acc && exp_rel[0]);
      else             expect_busy = any_pend;
      if (acc) begin
         if (exp_rel[0]) last_gnt = g;
         head[g]++;
         void'(exp_gnt.pop_front());
         void'(exp_data.pop_front());
         void'(exp_rel.pop_front());
         writes_seen++;
      end
   endtask

   task automatic run_drain(input int max_cyc, input int full_pct, input bit rand_stall);
      int c;
      c = 0;
      while ((exp_gnt.size() > 0 || expect_busy) && c < max_cyc) begin
         cycle((full_pct > 0) && ($urandom_range(0, 99) < full_pct),
               rand_stall && ($urandom_range(0, 3) == 0));
         c++;
      end
      check("drain_remaining", exp_gnt.size(), 0);
   endtask

   initial begin
      wrst_n        = 1'b0;
      bus.req_valid = '1;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.full      = 1'b0;
      for (int r = 0; r < NR; r++) begin
         head[r] = 0;
         tail[r] = 0;
      end
      model_ptr   = 0;
      expect_busy = 1'b0;
      last_gnt    = 0;
      writes_seen = 0;

      // Reset held with every requester valid: all outputs stay quiet.
      repeat (3) @(negedge w_clk);
      #1;
      check("rst_w_en", 32'(bus.w_en), 0);
      check("rst_req_ready", 32'(bus.req_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_gnt_id", 32'(gnt_id), 0);
      check("rst_data_in", 32'(bus.data_in), 0);
      bus.req_valid = '0;
      wrst_n        = 1'b1;

      // Fairness: two 2-beat packets per requester, expected grant order 0,1,2,3,0,1,2,3.
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < NR; r++) push_packet(r, 2);
      build_expect();
      run_drain(200, 0, 1'b0);

      // Forced release: a 20-beat packet on requester 1 is cut at 16; requester 2 gets in between.
      push_packet(1, 20);
      push_packet(2, 3);
      build_expect();
      run_drain(200, 0, 1'b0);

      // Backpressure: full held for 5 cycles in the middle of an 8-beat packet.
      push_packet(0, 8);
      build_expect();
      repeat (4) cycle(1'b0, 1'b0);
      repeat (5) cycle(1'b1, 1'b0);
      run_drain(100, 0, 1'b0);

      // Reset mid-burst: drop wrst_n while beat 3 of 8 is on the bus.
      push_packet(2, 8);
      build_expect();
      writes_seen = 0;
      for (int c = 0; c < 20 && writes_seen < 2; c++) cycle(1'b0, 1'b0);
      check("mb_two_written", writes_seen, 2);
      begin
         logic any_pend;
         @(negedge w_clk);
         drive_inputs(1'b0, 1'b0, any_pend);
         #1;
         check("mb_w_en_before", 32'(bus.w_en), 1);
         wrst_n = 1'b0;
         #1;
         check("mb_rst_w_en", 32'(bus.w_en), 0);
         check("mb_rst_req_ready", 32'(bus.req_ready), 0);
         check("mb_rst_busy", 32'(busy), 0);
         check("mb_rst_gnt_id", 32'(gnt_id), 0);
         check("mb_rst_data_in", 32'(bus.data_in), 0);
         for (int r = 0; r < NR; r++) head[r] = tail[r];
         exp_gnt.delete();
         exp_data.delete();
         exp_rel.delete();
         expect_busy = 1'b0;
         model_ptr   = 0;
         last_gnt    = 0;
         drive_inputs(1'b0, 1'b0, any_pend);
         @(negedge w_clk);
         wrst_n = 1'b1;
      end

      // Sparse: only requester 3 is valid, so it is found by the wrapping search from pointer 0.
      push_packet(3, 3);
      build_expect();
      run_drain(100, 0, 1'b0);

      // The pointer wrapped back to 0, so requester 0 goes ahead of requester 3.
      push_packet(3, 2);
      push_packet(0, 2);
      build_expect();
      run_drain(100, 0, 1'b0);

      // Random packets with random backpressure and stalls by the granted requester.
      for (int p = 0; p < 3; p++)
         for (int r = 0; r < NR; r++) push_packet(r, $urandom_range(1, 20));
      build_expect();
      run_drain(3000, 25, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the async FIFO among `NUM_REQ` packet-oriented requesters. It sits entirely in the write clock domain, directly in front of the FIFO's `data_in` / `w_en` / `full` interface. It grants one requester at a time for a whole packet, capped at `MAX_BURST` beats. It also honours FIFO backpressure, so no write is ever issued while `full` is high.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters (≥2).
- `data_width`, 8 — beat width; matches the FIFO.
- `MAX_BURST`, 16 — maximum beats per grant before forced release (≥1).

Ports:
- `w_clk` in 1 — write-domain clock; the only clock.
- `wrst_n` in 1 — asynchronous, active-low reset.
- `req_valid` in NUM_REQ — per-requester beat valid.
- `req_data` in NUM_REQ*data_width — flattened beats; requester i occupies bits [i*data_width +: data_width].
- `req_last` in NUM_REQ — marks the final beat of a packet.
- `req_ready` out NUM_REQ — beat accepted when `req_valid[i] & req_ready[i]`.
- `full` in 1 — FIFO full flag, already in the `w_clk` domain.
- `w_en` out 1 — FIFO write enable.
- `data_in` out data_width — FIFO write data.
- `gnt_id` out $clog2(NUM_REQ) — index of the current or last granted requester.
- `busy` out 1 — high while a grant is held.

## Operation
- Two states: ARB_IDLE and ARB_BURST.
- **ARB_IDLE**
  - If any `req_valid` is high, pick the first set index at or after `rr_ptr`, searching upward with wrap.
  - Register the pick into `gnt_id`, clear `beat_cnt`, and move to ARB_BURST.
  - If no request is valid, stay in ARB_IDLE.
- **ARB_BURST**
  - `req_ready[gnt_id] = ~full`; every other `req_ready` bit is 0.
  - `w_en = req_valid[gnt_id] & ~full`; `data_in` = the granted slice of `req_data`.
  - On each accepted beat, `beat_cnt` increments.
- **Release**
  - Release occurs on an accepted beat with `req_last[gnt_id]=1`, or on the accepted beat where `beat_cnt == MAX_BURST-1`.
  - On release: `rr_ptr <= (gnt_id+1) mod NUM_REQ`, state goes to ARB_IDLE.
- **Backpressure:** while `full` is high, no beat is accepted and the grant is held indefinitely. There is no timeout.
- **Stalled requester:** if the granted requester drops `req_valid` mid-packet, the grant is held with no beat accepted.
- **Forced release:** the packet's remaining beats are re-arbitrated later. A requester continuing a cut packet is not given priority.
- `busy` = (state == ARB_BURST).
- **Counter width:** `beat_cnt` is $clog2(MAX_BURST+1) bits and never wraps.
- **Pointer width:** `rr_ptr` wraps modulo `NUM_REQ`, including non-power-of-two values.

## Timing
- **Reset values:** state ARB_IDLE, `rr_ptr`=0, `gnt_id`=0, `beat_cnt`=0, `busy`=0, `w_en`=0, `req_ready`=0, `data_in`=0.
  - `data_in` is forced to 0 whenever not in ARB_BURST.
- **Registered / combinational split:** state, `gnt_id`, `rr_ptr` and `beat_cnt` are registered. `w_en`, `req_ready` and `data_in` are combinational from the registered state, `full`, and the granted requester's inputs.
- **Grant latency:** a request seen in ARB_IDLE in cycle N is granted at the N→N+1 edge. The first beat can be written in cycle N+1.
- **Throughput:** one beat per cycle while granted and not full.
- **Turnaround:** one dead ARB_IDLE cycle between consecutive grants.
- **Reset mid-burst:** `wrst_n` low forces all outputs to their reset values immediately; no write is issued. The partial packet is lost.
- **`full` timing:** `full` is sampled combinationally in the same cycle, so `full` rising in cycle N blocks the write in cycle N.

## Structure
- Shared package `fifo_arb_pkg`:
  - `arb_state_t` enum {ARB_IDLE, ARB_BURST}.
  - Default constants `ARB_NUM_REQ` = 4 and `ARB_MAX_BURST` = 16.
- One combinational sub-module `rr_pick`:
  - Inputs: `NUM_REQ`-bit request vector and start pointer.
  - Outputs: `found` flag and `idx`.
- `fifo_wr_arbiter` holds the FSM, counters and output muxing. It instantiates alongside `top`, driving its `data_in` and `w_en`.

## Test plan
- **Reset:** assert `wrst_n`=0 with all `req_valid`=1 → `w_en`=0, `req_ready`=0, `busy`=0, `gnt_id`=0. After release, requester 0 is granted first.
- **Fairness:** all 4 requesters send continuous 2-beat packets → grants follow the order 0,1,2,3,0,… Each packet is 2 writes followed by 1 idle cycle; no beat is lost or reordered.
- **Forced release:** requester 1 sends a 20-beat packet with `MAX_BURST`=16 and requester 2 is valid → 16 beats are written, then requester 2 is granted. Requester 1's last 4 beats follow after requester 2's packet.
- **Backpressure:** `full` is raised for 5 cycles mid-packet → `w_en`=0 and `req_ready`=0 for exactly those cycles. `gnt_id` is unchanged and writing resumes on the next beat after `full` falls.
- **Reset mid-burst:** `wrst_n` is pulsed low on beat 3 of 8 → outputs drop in the same cycle. After release the state is ARB_IDLE and `rr_ptr`=0.
- **Sparse requests:** a single requester 3 is valid with `rr_ptr`=0 → it is granted after the wrap search. After its `req_last`, `rr_ptr`=0.
